// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU
// load/store port (0) and the debug/loader port (1). Round-robin grant with
// an optional lock that keeps ownership across a read-modify-write pair.
//
// state | meaning
// ------+--------------------------------------------------------------
// FREE  | no owner; grants follow round-robin using last_q
// LOCK0 | port 0 owns the bus; port 1 waits until the lock is released
// LOCK1 | port 1 owns the bus; port 0 waits until the lock is released
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock0,
  input  logic              i_lock1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt0, gnt1;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Owner state and round-robin pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FREE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Grant decision and next owner; a lock release only takes effect at the edge.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      FREE: begin
        if (i_req0 && i_req1) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = i_req0;
          gnt1 = i_req1;
        end
      end
      LOCK0:   gnt0 = i_req0;
      LOCK1:   gnt1 = i_req1;
      default: ;
    endcase

    if (gnt0) begin
      last_d  = 1'b0;
      state_d = i_lock0 ? LOCK0 : FREE;
    end else if (gnt1) begin
      last_d  = 1'b1;
      state_d = i_lock1 ? LOCK1 : FREE;
    end else if (state_q == LOCK0) begin
      // Owner idle: release only when it also drops its lock.
      if (!i_lock0) state_d = FREE;
    end else if (state_q == LOCK1) begin
      if (!i_lock1) state_d = FREE;
    end else if (state_q != FREE) begin
      state_d = FREE;
    end
  end

  // Memory mux: the granted port drives the memory, otherwise all zeros.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (gnt0) begin
      o_mem_we    = i_we0;
      o_mem_addr  = i_addr0;
      o_mem_wdata = i_wdata0;
    end else if (gnt1) begin
      o_mem_we    = i_we1;
      o_mem_addr  = i_addr1;
      o_mem_wdata = i_wdata1;
    end
  end

  // Read data captured on a grant (pre-write contents for writes), else held.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (gnt0) rdata0_d = i_mem_rdata;
    if (gnt1) rdata1_d = i_mem_rdata;
  end

  // Response registers: one-cycle rvalid pulse per grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign o_gnt0    = gnt0;
  assign o_gnt1    = gnt1;
  assign o_rvalid0 = rvalid0_q;
  assign o_rvalid1 = rvalid1_q;
  assign o_rdata0  = rdata0_q;
  assign o_rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 64-word memory model, a port-level reference
// model of ownership/round-robin/responses, a directed vector table, random
// traffic, and hand-written reset sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_lock0(lock0), .i_lock1(lock1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

  // Reference model: owner (-1 none, else port), last grant, shadow memory.
  int          m_owner;
  int          m_last;
  logic [31:0] shadow [0:63];
  logic        m_rv [2];
  logic [31:0] m_rd [2];

  int n_total = 0;
  int n_pass  = 0;
  logic        s_gnt0, s_gnt1;
  logic [31:0] s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle(input logic r0, input logic w0, input logic l0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [31:0] a1, input logic [31:0] d1);
    int          g;
    logic        r [2];
    logic        w [2];
    logic        l [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    r[0] = r0; w[0] = w0; l[0] = l0; a[0] = a0; d[0] = d0;
    r[1] = r1; w[1] = w1; l[1] = l1; a[1] = a1; d[1] = d1;
    @(negedge clk);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    g = -1;
    if (m_owner >= 0) begin
      if (r[m_owner]) g = m_owner;
    end else if (r[0] && r[1]) g = 1 - m_last;
    else if (r[0]) g = 0;
    else if (r[1]) g = 1;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    if (g >= 0) begin
      exp_we = w[g]; exp_addr = a[g]; exp_wdata = d[g];
    end
    chk("gnt0", {31'd0, gnt0}, {31'd0, g == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, g == 1});
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_addr = mem_addr;
    @(posedge clk);
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    if (g >= 0) begin
      m_rv[g] = 1'b1;
      m_rd[g] = shadow[a[g][5:0]];
      if (w[g]) shadow[a[g][5:0]] = d[g];
      m_last  = g;
      m_owner = l[g] ? g : -1;
    end else if (m_owner >= 0 && !l[m_owner]) begin
      m_owner = -1;
    end
    #1;
    chk("rvalid0", {31'd0, rvalid0}, {31'd0, m_rv[0]});
    chk("rvalid1", {31'd0, rvalid1}, {31'd0, m_rv[1]});
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
  endtask

  // Idle the ports, assert reset asynchronously, check cleared outputs, release.
  task automatic do_reset();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    rst_n = 1'b0;
    #1;
    m_owner = -1; m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        eg0, eg1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'h0101_0101 * i;
      shadow[i] = 32'h0101_0101 * i;
    end
    mem[4] = 32'hDEAD_BEEF; shadow[4] = 32'hDEAD_BEEF;

    // contention, write-then-read, lock RMW, lock hold/release
    tbl[0]  = '{1,0,0, 1,0, 1,0,0, 2,0, 1,0};
    tbl[1]  = '{1,0,0, 1,0, 1,0,0, 2,0, 0,1};
    tbl[2]  = '{1,0,0, 1,0, 1,0,0, 2,0, 1,0};
    tbl[3]  = '{1,0,0, 1,0, 1,0,0, 2,0, 0,1};
    tbl[4]  = '{1,0,0, 1,0, 1,0,0, 2,0, 1,0};
    tbl[5]  = '{1,0,0, 1,0, 1,0,0, 2,0, 0,1};
    tbl[6]  = '{0,0,0, 0,0, 1,1,0, 7,32'h1234_5678, 0,1};
    tbl[7]  = '{1,0,0, 7,0, 0,0,0, 0,0, 1,0};
    tbl[8]  = '{1,0,0, 5,0, 1,0,1, 3,0, 0,1};
    tbl[9]  = '{1,0,0, 5,0, 1,1,0, 3,32'hA5A5_0003, 0,1};
    tbl[10] = '{1,0,0, 5,0, 0,0,0, 0,0, 1,0};
    tbl[11] = '{1,0,1, 6,0, 0,0,0, 0,0, 1,0};
    tbl[12] = '{0,0,1, 0,0, 1,0,0, 8,0, 0,0};
    tbl[13] = '{0,0,0, 0,0, 1,0,0, 8,0, 0,0};
    tbl[14] = '{0,0,0, 0,0, 1,0,0, 8,0, 0,1};

    do_reset();

    // Single read of preloaded word 4.
    cycle(1,0,0, 4,0, 0,0,0, 0,0);
    chk("single_gnt0", {31'd0, s_gnt0}, 32'd1);
    chk("single_addr", s_addr, 32'd4);
    chk("single_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("single_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("single_rvalid1", {31'd0, rvalid1}, 32'd0);

    // Directed table from a fresh reset.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
      chk($sformatf("tbl%0d_gnt0", i), {31'd0, s_gnt0}, {31'd0, tbl[i].eg0});
      chk($sformatf("tbl%0d_gnt1", i), {31'd0, s_gnt1}, {31'd0, tbl[i].eg1});
      if (i == 6) chk("wr_ack_rvalid1", {31'd0, rvalid1}, 32'd1);
      if (i == 7) chk("rd_after_wr", rdata0, 32'h1234_5678);
    end

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            32'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            32'($urandom_range(0, 15)), $urandom);
    end

    // Reset mid-traffic with a response pending, then first tie goes to port 0.
    do_reset();
    cycle(1,0,0, 1,0, 1,0,0, 2,0);
    cycle(1,0,0, 1,0, 1,0,0, 2,0);
    do_reset();
    cycle(1,0,0, 3,0, 1,0,0, 4,0);
    chk("post_rst_tie_gnt0", {31'd0, s_gnt0}, 32'd1);

    // Reset while port 0 holds the lock: port 1 granted right after.
    cycle(1,0,1, 9,0, 0,0,0, 0,0);
    cycle(0,0,1, 0,0, 1,0,0, 10,0);
    chk("locked_wait_gnt1", {31'd0, s_gnt1}, 32'd0);
    do_reset();
    cycle(0,0,0, 0,0, 1,0,0, 10,0);
    chk("post_lock_rst_gnt1", {31'd0, s_gnt1}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
